// File: rtl/postcode_txq.sv
// POST-port pod engine: answers host REQ pulses with break / preamble / status / data
// framing and sends queued frames back-to-back on chained INPUT commands.
module postcode_txq #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PREAMBLE     = 2,
    parameter int BREAK_CYCLES = 40,
    parameter int LSB_FIRST    = 0
) (
    input  logic                          refclk,
    input  logic                          nreset,
    input  logic                          testreq,
    output logic                          testack,
    input  logic [DATA_W-1:0]             txin,
    input  logic                          tx_pending,
    output logic                          want_tx,
    input  logic                          rx_ready,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_sent,
    output logic                          tx_abort
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int KW = $clog2(BREAK_CYCLES + 1);
    localparam int PW = (PREAMBLE > 1) ? $clog2(PREAMBLE) : 1;

    typedef enum logic [1:0] {PRE, XBIT, YBIT, DATA} state_t;

    state_t            state, state_n;
    logic              req_s1, req_s2, req_d;
    logic              req_fall, brk;
    logic [KW-1:0]     brk_cnt;
    logic [PW-1:0]     pre_cnt, pre_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic              ack_n, y, y_n, eval_y, pop, push;
    logic [DATA_W-1:0] shreg, sh_n, head, shifted;
    logic              out_bit;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    // Input synchroniser and pulse-edge / break detection
    always_ff @(posedge refclk or negedge nreset) begin
        if (!nreset) begin
            req_s1  <= 1'b0;
            req_s2  <= 1'b0;
            req_d   <= 1'b0;
            brk_cnt <= '0;
        end else begin
            req_s1 <= testreq;
            req_s2 <= req_s1;
            req_d  <= req_s2;
            if (req_s2)
                brk_cnt <= '0;
            else if (brk_cnt != KW'(BREAK_CYCLES))
                brk_cnt <= brk_cnt + KW'(1);
        end
    end

    assign req_fall = req_d & ~req_s2;
    assign brk      = ~req_s2 && (brk_cnt == KW'(BREAK_CYCLES - 1));

    // Transmit queue
    assign push    = tx_pending && want_tx;
    assign want_tx = (fifo_level != (AW + 1)'(FIFO_DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge refclk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (push && !flush) mem[wr_ptr] <= txin;
    end

    // Protocol FSM: state register
    always_ff @(posedge refclk or negedge nreset) begin
        if (!nreset) begin
            state   <= PRE;
            pre_cnt <= '0;
            bit_cnt <= '0;
            testack <= 1'b0;
            y       <= 1'b0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_n;
            bit_cnt <= bit_n;
            testack <= ack_n;
            y       <= y_n;
        end
    end

    always_ff @(posedge refclk) begin
        shreg <= sh_n;
    end

    assign out_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_W-1];
    assign shifted = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

    // Next-state logic; y evaluation pops the head into the shift register
    always_comb begin
        state_n = state;
        pre_n   = pre_cnt;
        bit_n   = bit_cnt;
        ack_n   = testack;
        y_n     = y;
        sh_n    = shreg;
        eval_y  = 1'b0;
        pop     = 1'b0;
        if (brk) begin
            state_n = PRE;
            pre_n   = '0;
            bit_n   = '0;
            ack_n   = 1'b0;
            y_n     = 1'b0;
            sh_n    = '0;
        end else if (req_fall) begin
            unique case (state)
                PRE: begin
                    if (pre_cnt == PW'(PREAMBLE - 1)) begin
                        state_n = XBIT;
                        pre_n   = '0;
                        ack_n   = rx_ready;
                    end else begin
                        pre_n = pre_cnt + PW'(1);
                        ack_n = 1'b0;
                    end
                end
                XBIT: begin
                    state_n = YBIT;
                    eval_y  = 1'b1;
                end
                YBIT: begin
                    if (y) begin
                        state_n = DATA;
                        bit_n   = '0;
                        ack_n   = out_bit;
                        sh_n    = shifted;
                    end else begin
                        eval_y = 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BW'(DATA_W - 1)) begin
                        state_n = YBIT;
                        eval_y  = 1'b1;
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                        ack_n = out_bit;
                        sh_n  = shifted;
                    end
                end
                default: state_n = PRE;
            endcase
        end
        if (eval_y) begin
            y_n   = (fifo_level != '0) && !flush;
            ack_n = y_n;
            pop   = y_n;
            if (y_n) sh_n = head;
        end
    end

    // Output strobes
    always_comb begin
        tx_sent  = req_fall && !brk && (state == DATA) && (bit_cnt == BW'(DATA_W - 1));
        tx_abort = brk && (state == DATA);
    end
endmodule

// File: tb/tb_postcode_txq.sv
// Bench for postcode_txq: a host-side model predicts every ACK bit of each poll from
// the queued frames, plus directed checks of levels, strobes, bit order and reset.
module tb_postcode_txq;
    localparam int DW  = 8;
    localparam int PRE = 2;
    localparam int BRK = 40;

    logic       refclk = 1'b0;
    logic       nreset = 1'b0;
    logic       testreq = 1'b0;
    logic       tx_pending = 1'b0;
    logic       rx_ready = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] txin = '0;
    logic       testack, want_tx, tx_sent, tx_abort;
    logic [4:0] fifo_level;
    logic       ack_l, want_l, sent_l, abort_l;
    logic [4:0] level_l;

    always #5 refclk = ~refclk;

    postcode_txq dut (
        .refclk(refclk), .nreset(nreset), .testreq(testreq), .testack(testack),
        .txin(txin), .tx_pending(tx_pending), .want_tx(want_tx), .rx_ready(rx_ready),
        .flush(flush), .fifo_level(fifo_level), .tx_sent(tx_sent), .tx_abort(tx_abort)
    );

    postcode_txq #(.LSB_FIRST(1)) dut_lsb (
        .refclk(refclk), .nreset(nreset), .testreq(testreq), .testack(ack_l),
        .txin(txin), .tx_pending(tx_pending), .want_tx(want_l), .rx_ready(rx_ready),
        .flush(flush), .fifo_level(level_l), .tx_sent(sent_l), .tx_abort(abort_l)
    );

    int nerr = 0, nchk = 0, sent_cnt = 0, abort_cnt = 0, exp_sent = 0;
    logic [7:0] mq[$];
    bit         e[$];

    always @(negedge refclk) begin
        if (tx_sent)  sent_cnt++;
        if (tx_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        @(negedge refclk);
        txin = v;
        tx_pending = 1'b1;
        if (want_tx) mq.push_back(v);
        @(negedge refclk);
        tx_pending = 1'b0;
    endtask

    task automatic do_break();
        testreq = 1'b0;
        repeat (BRK + 6) @(negedge refclk);
    endtask

    task automatic pulse(output logic a);
        @(negedge refclk);
        testreq = 1'b1;
        repeat (2) @(negedge refclk);
        a = testack;
        repeat (2) @(negedge refclk);
        testreq = 1'b0;
        repeat (5) @(negedge refclk);
    endtask

    // Host view of a poll: preamble zeros, x, then y=1 + frame bits per queued frame, else y=0
    task automatic start_poll(input int n, input logic rx);
        logic [7:0] f;
        rx_ready = rx;
        do_break();
        e.delete();
        exp_sent = sent_cnt;
        repeat (PRE) e.push_back(1'b0);
        e.push_back(rx);
        while (e.size() < n + 1) begin
            if (mq.size() > 0) begin
                f = mq.pop_front();
                e.push_back(1'b1);
                for (int i = DW - 1; i >= 0; i--) e.push_back(f[i]);
                if (e.size() <= n) exp_sent++;
            end else begin
                e.push_back(1'b0);
            end
        end
    endtask

    task automatic send(input int from, input int to);
        logic a;
        for (int i = from; i < to; i++) begin
            pulse(a);
            chk($sformatf("ack[%0d]", i), a, e[i]);
        end
    endtask

    task automatic end_poll(input int n, input string tag);
        chk({tag, " final ack"}, testack, e[n]);
        chk({tag, " tx_sent count"}, sent_cnt, exp_sent);
    endtask

    initial begin
        int k, n, a0, s0;
        logic [7:0] chain [5];
        chain = '{8'h5A, 8'hC3, 8'h01, 8'hFF, 8'h80};

        repeat (3) @(negedge refclk);
        chk("rst testack", testack, 0);
        chk("rst want_tx", want_tx, 1);
        chk("rst level", fifo_level, 0);
        chk("rst tx_sent", tx_sent, 0);
        chk("rst tx_abort", tx_abort, 0);
        nreset = 1'b1;

        start_poll(7, 1'b1);
        send(0, 7);
        end_poll(7, "empty");
        chk("empty level", fifo_level, 0);

        push(8'h5A);
        chk("push level", fifo_level, 1);
        start_poll(12, 1'($urandom_range(0, 1)));
        send(0, 12);
        end_poll(12, "single");
        chk("single level", fifo_level, 0);

        for (int i = 0; i < 5; i++) push(chain[i]);
        start_poll(48, 1'b0);
        send(0, 48);
        end_poll(48, "chain");

        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) push(8'($urandom));
        n = 4 + k * 9 - 1;
        start_poll(n, 1'($urandom_range(0, 1)));
        send(0, n);
        end_poll(n, "random");

        for (int i = 0; i < 16; i++) push(8'($urandom));
        chk("full want_tx", want_tx, 0);
        chk("full level", fifo_level, 16);
        push(8'hEE);
        chk("overfill level", fifo_level, 16);
        start_poll(147, 1'b1);
        send(0, 4);
        chk("drain1 level", fifo_level, 15);
        chk("drain1 want_tx", want_tx, 1);
        send(4, 147);
        end_poll(147, "full");
        chk("full drained", fifo_level, 0);

        for (int i = 0; i < 3; i++) push(8'($urandom));
        chk("preflush level", fifo_level, 3);
        @(negedge refclk);
        flush = 1'b1;
        @(negedge refclk);
        flush = 1'b0;
        mq.delete();
        chk("flush level", fifo_level, 0);
        start_poll(5, 1'b1);
        send(0, 5);
        end_poll(5, "flush");

        chk("abort count before", abort_cnt, 0);
        push(8'hA5);
        push(8'h3C);
        start_poll(7, 1'b0);
        send(0, 7);
        a0 = abort_cnt;
        s0 = sent_cnt;
        do_break();
        chk("abort pulse", abort_cnt - a0, 1);
        chk("abort no sent", sent_cnt - s0, 0);
        chk("abort ack", testack, 0);
        start_poll(12, 1'b1);
        send(0, 12);
        end_poll(12, "after abort");
        chk("abort total", abort_cnt, 1);

        @(negedge refclk);
        nreset = 1'b0;
        @(negedge refclk);
        nreset = 1'b1;
        mq.delete();
        push(8'h01);
        start_poll(12, 1'b1);
        send(0, 4);
        chk("msb first bit", testack, e[4]);
        chk("lsb first bit", ack_l, 1);
        send(4, 7);
        a0 = abort_cnt;
        @(negedge refclk);
        nreset = 1'b0;
        @(negedge refclk);
        chk("mid rst testack", testack, 0);
        chk("mid rst want_tx", want_tx, 1);
        chk("mid rst level", fifo_level, 0);
        chk("mid rst tx_sent", tx_sent, 0);
        chk("mid rst tx_abort", tx_abort, 0);
        chk("mid rst lsb testack", ack_l, 0);
        chk("mid rst lsb level", level_l, 0);
        chk("mid rst lsb strobes", {sent_l, abort_l, want_l}, 3'b001);
        chk("mid rst no abort", abort_cnt - a0, 0);
        nreset = 1'b1;
        repeat (2) @(negedge refclk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
